// File: rtl/elevator_dispatcher_pkg.sv
// Shared types and defaults for the elevator dispatcher slice.
package elevator_dispatcher_pkg;

    localparam int DEFAULT_NUM_FLOORS = 10;

    // Top-level controller states
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        MOVE_UP   = 2'd1,
        MOVE_DOWN = 2'd2,
        DOOR_OPEN = 2'd3
    } state_t;

    // Sweep direction remembered between stops so SCAN keeps going the same way
    typedef enum logic {
        UP   = 1'b0,
        DOWN = 1'b1
    } dir_t;

endpackage

// File: rtl/elevator_dispatcher_if.sv
// Bundle between the request latch bank / car peripherals and the dispatcher.
interface elevator_dispatcher_if
    import elevator_dispatcher_pkg::*;
#(
    parameter int NUM_FLOORS = DEFAULT_NUM_FLOORS,
    parameter int FLOOR_W    = $clog2(NUM_FLOORS)
);
    logic [NUM_FLOORS-1:0] requests;
    logic [NUM_FLOORS-1:0] resetSome;
    logic [FLOOR_W-1:0]    currentFloor;
    logic                  movingUp;
    logic                  movingDown;
    logic                  doorOpen;

    // Latch bank and car peripherals
    modport master (
        output requests,
        input  resetSome, currentFloor, movingUp, movingDown, doorOpen
    );

    // Dispatcher
    modport slave (
        input  requests,
        output resetSome, currentFloor, movingUp, movingDown, doorOpen
    );
endinterface

// File: rtl/elevator_tick_timer.sv
// Loadable down-counter; done is high while the count sits at zero.
module elevator_tick_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             en,
    output logic             done
);
    logic [CNT_W-1:0] cnt;

    // Load has priority over counting; the count parks at zero
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en && (cnt != '0)) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign done = (cnt == '0);
endmodule

// File: rtl/elevator_dispatcher.sv
// SCAN elevator dispatcher: serves latched floor requests, one floor per
// FLOOR_TICKS cycles, holding the door DOOR_TICKS cycles and clearing the
// served floor's latch while the door is open.
module elevator_dispatcher
    import elevator_dispatcher_pkg::*;
#(
    parameter int NUM_FLOORS  = DEFAULT_NUM_FLOORS,
    parameter int FLOOR_TICKS = 50000000,
    parameter int DOOR_TICKS  = 150000000,
    parameter int FLOOR_W     = $clog2(NUM_FLOORS)
) (
    input  logic                 clk,
    input  logic                 reset,
    elevator_dispatcher_if.slave bus
);
    localparam int MAX_TICKS = (FLOOR_TICKS > DOOR_TICKS) ? FLOOR_TICKS : DOOR_TICKS;
    localparam int CNT_W     = ($clog2(MAX_TICKS) < 1) ? 1 : $clog2(MAX_TICKS);

    // The timer reaches zero after (load value) decrements, so load N-1 for N cycles
    localparam logic [CNT_W-1:0]   FLOOR_LOAD = CNT_W'(FLOOR_TICKS - 1);
    localparam logic [CNT_W-1:0]   DOOR_LOAD  = CNT_W'(DOOR_TICKS - 1);
    localparam logic [FLOOR_W-1:0] TOP_FLOOR  = FLOOR_W'(NUM_FLOORS - 1);

    state_t                state, state_n;
    dir_t                  last_dir, dir_n;
    logic [FLOOR_W-1:0]    cur_floor, floor_n;
    logic                  here, above, below;
    logic                  t_load, t_en, t_done;
    logic [CNT_W-1:0]      t_val;
    logic [NUM_FLOORS-1:0] reset_some_q;
    logic                  moving_up_q, moving_down_q, door_open_q;

    function automatic logic req_at(input logic [NUM_FLOORS-1:0] r,
                                    input logic [FLOOR_W-1:0] f);
        logic v;
        v = 1'b0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (i == int'(f)) v = r[i];
        end
        return v;
    endfunction

    function automatic logic any_above(input logic [NUM_FLOORS-1:0] r,
                                       input logic [FLOOR_W-1:0] f);
        logic v;
        v = 1'b0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (i > int'(f)) v = v | r[i];
        end
        return v;
    endfunction

    function automatic logic any_below(input logic [NUM_FLOORS-1:0] r,
                                       input logic [FLOOR_W-1:0] f);
        logic v;
        v = 1'b0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (i < int'(f)) v = v | r[i];
        end
        return v;
    endfunction

    function automatic logic [NUM_FLOORS-1:0] floor_onehot(input logic [FLOOR_W-1:0] f);
        logic [NUM_FLOORS-1:0] v;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            v[i] = (i == int'(f));
        end
        return v;
    endfunction

    elevator_tick_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (t_load),
        .load_val (t_val),
        .en       (t_en),
        .done     (t_done)
    );

    // Request summary relative to the floor the car is at now
    always_comb begin
        here  = req_at(bus.requests, cur_floor);
        above = any_above(bus.requests, cur_floor);
        below = any_below(bus.requests, cur_floor);
    end

    // Next-state, next-floor and timer control
    always_comb begin
        state_n = state;
        floor_n = cur_floor;
        dir_n   = last_dir;
        t_load  = 1'b0;
        t_val   = '0;
        t_en    = 1'b0;
        case (state)
            IDLE: begin
                if (here) begin
                    state_n = DOOR_OPEN;
                    t_load  = 1'b1;
                    t_val   = DOOR_LOAD;
                end else if (above && (last_dir == UP || !below)) begin
                    state_n = MOVE_UP;
                    dir_n   = UP;
                    t_load  = 1'b1;
                    t_val   = FLOOR_LOAD;
                end else if (below) begin
                    state_n = MOVE_DOWN;
                    dir_n   = DOWN;
                    t_load  = 1'b1;
                    t_val   = FLOOR_LOAD;
                end
            end
            MOVE_UP: begin
                if (t_done) begin
                    // Step completes even if the target vanished; decide on the new floor
                    floor_n = (cur_floor == TOP_FLOOR) ? cur_floor : cur_floor + FLOOR_W'(1);
                    if (req_at(bus.requests, floor_n)) begin
                        state_n = DOOR_OPEN;
                        t_load  = 1'b1;
                        t_val   = DOOR_LOAD;
                    end else if (any_above(bus.requests, floor_n)) begin
                        t_load  = 1'b1;
                        t_val   = FLOOR_LOAD;
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    t_en = 1'b1;
                end
            end
            MOVE_DOWN: begin
                if (t_done) begin
                    floor_n = (cur_floor == '0) ? cur_floor : cur_floor - FLOOR_W'(1);
                    if (req_at(bus.requests, floor_n)) begin
                        state_n = DOOR_OPEN;
                        t_load  = 1'b1;
                        t_val   = DOOR_LOAD;
                    end else if (any_below(bus.requests, floor_n)) begin
                        t_load  = 1'b1;
                        t_val   = FLOOR_LOAD;
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    t_en = 1'b1;
                end
            end
            DOOR_OPEN: begin
                // Presses at this floor are ignored here; the latch is held clear
                if (t_done) begin
                    state_n = IDLE;
                end else begin
                    t_en = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Controller state plus registered decodes of the state being entered
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            cur_floor     <= '0;
            last_dir      <= UP;
            reset_some_q  <= '0;
            moving_up_q   <= 1'b0;
            moving_down_q <= 1'b0;
            door_open_q   <= 1'b0;
        end else begin
            state         <= state_n;
            cur_floor     <= floor_n;
            last_dir      <= dir_n;
            reset_some_q  <= (state_n == DOOR_OPEN) ? floor_onehot(floor_n) : '0;
            moving_up_q   <= (state_n == MOVE_UP);
            moving_down_q <= (state_n == MOVE_DOWN);
            door_open_q   <= (state_n == DOOR_OPEN);
        end
    end

    assign bus.resetSome    = reset_some_q;
    assign bus.currentFloor = cur_floor;
    assign bus.movingUp     = moving_up_q;
    assign bus.movingDown   = moving_down_q;
    assign bus.doorOpen     = door_open_q;
endmodule

// File: tb/tb_elevator_dispatcher.sv
// Bench for elevator_dispatcher: a clocked request latch bank feeds the DUT,
// a cycle-level behavioural model of the SCAN rules predicts every output.
module tb_elevator_dispatcher;
    localparam int NF = 10;
    localparam int FT = 4;
    localparam int DT = 3;
    localparam int FW = $clog2(NF);

    localparam int M_IDLE = 0;
    localparam int M_UP   = 1;
    localparam int M_DOWN = 2;
    localparam int M_DOOR = 3;

    logic clk = 1'b0;
    logic reset;

    elevator_dispatcher_if #(.NUM_FLOORS(NF)) bus ();

    elevator_dispatcher #(
        .NUM_FLOORS  (NF),
        .FLOOR_TICKS (FT),
        .DOOR_TICKS  (DT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Model: position, activity, cycles left in current activity, sweep (+1/-1)
    int m_pos  = 0;
    int m_mode = M_IDLE;
    int m_left = 0;
    int m_dir  = 1;

    function automatic bit ahead(input logic [NF-1:0] r, input int f, input int d);
        for (int i = 0; i < NF; i++) begin
            if ((i - f) * d > 0 && r[i]) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic logic [NF-1:0] m_clear();
        logic [NF-1:0] one;
        one = 1;
        return (m_mode == M_DOOR) ? (one << m_pos) : '0;
    endfunction

    task automatic model_step(input logic [NF-1:0] r, input logic rst);
        int d;
        if (rst) begin
            m_pos = 0; m_mode = M_IDLE; m_left = 0; m_dir = 1;
            return;
        end
        case (m_mode)
            M_IDLE: begin
                if (r[m_pos]) begin
                    m_mode = M_DOOR; m_left = DT;
                end else if (ahead(r, m_pos, 1) && (m_dir == 1 || !ahead(r, m_pos, -1))) begin
                    m_mode = M_UP; m_dir = 1; m_left = FT;
                end else if (ahead(r, m_pos, -1)) begin
                    m_mode = M_DOWN; m_dir = -1; m_left = FT;
                end
            end
            M_UP, M_DOWN: begin
                d = (m_mode == M_UP) ? 1 : -1;
                m_left--;
                if (m_left == 0) begin
                    if (m_pos + d >= 0 && m_pos + d < NF) m_pos = m_pos + d;
                    if (r[m_pos]) begin
                        m_mode = M_DOOR; m_left = DT;
                    end else if (ahead(r, m_pos, d)) begin
                        m_left = FT;
                    end else begin
                        m_mode = M_IDLE;
                    end
                end
            end
            default: begin
                m_left--;
                if (m_left == 0) m_mode = M_IDLE;
            end
        endcase
    endtask

    task automatic compare();
        logic [NF-1:0] ers;
        ers = m_clear();
        checks++;
        if (bus.resetSome !== ers || bus.currentFloor !== FW'(m_pos) ||
            bus.movingUp !== (m_mode == M_UP) || bus.movingDown !== (m_mode == M_DOWN) ||
            bus.doorOpen !== (m_mode == M_DOOR)) begin
            failures++;
            $display("FAIL model_cycle t=%0t got rs=%h fl=%0d up=%b dn=%b door=%b required rs=%h fl=%0d mode=%0d",
                     $time, bus.resetSome, bus.currentFloor, bus.movingUp, bus.movingDown,
                     bus.doorOpen, ers, m_pos, m_mode);
        end
    endtask

    task automatic lit(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d required=%0d", name, got, exp);
        end
    endtask

    // One clock: latch bank sets on press, clears on resetSome (clear wins), or is wiped by clr
    task automatic tick(input logic [NF-1:0] press, input bit clr, input logic rst_next);
        logic [NF-1:0] nxt;
        nxt = clr ? '0 : ((bus.requests | press) & ~m_clear());
        model_step(bus.requests, reset);
        @(posedge clk);
        #1;
        bus.requests = nxt;
        reset = rst_next;
        @(negedge clk);
        compare();
    endtask

    task automatic settle(input string name, input int budget);
        int n;
        n = 0;
        while (!(m_mode == M_IDLE && bus.requests == '0) && n < budget) begin
            tick('0, 1'b0, 1'b0);
            n++;
        end
        lit(name, int'(n < budget), 1);
    endtask

    task automatic rehome();
        tick('0, 1'b1, 1'b1);
        tick('0, 1'b0, 1'b0);
    endtask

    initial begin
        int cnt_up, cnt_door, cnt_rs, door_fl, rises, maxfl, rs_seen, nd;
        int door_floors[$];
        int door_rs[$];
        logic prev_door;
        logic [NF-1:0] press;

        reset = 1'b1;
        bus.requests = 10'h3FF;

        // Reset held two edges with every floor requested
        tick('0, 1'b0, 1'b1);
        lit("rst_door", int'(bus.doorOpen), 0);
        lit("rst_floor", int'(bus.currentFloor), 0);
        lit("rst_rs", int'(bus.resetSome), 0);
        lit("rst_moving", int'({bus.movingUp, bus.movingDown}), 0);
        tick('0, 1'b0, 1'b0);
        tick('0, 1'b0, 1'b0);
        lit("rel_door", int'(bus.doorOpen), 1);
        lit("rel_rs", int'(bus.resetSome), 1);
        settle("rel_settle", 200);
        lit("rel_top", int'(bus.currentFloor), 9);

        // Door at floor 0
        rehome();
        tick(10'h001, 1'b0, 1'b0);
        cnt_door = 0;
        for (int k = 0; k < 10; k++) begin
            tick('0, 1'b0, 1'b0);
            if (k == 0) lit("t2_latency", int'(bus.doorOpen), 1);
            if (bus.doorOpen && bus.resetSome == 10'h001) cnt_door++;
        end
        lit("t2_door_cycles", cnt_door, 3);
        lit("t2_after", int'({bus.doorOpen, bus.movingUp, bus.movingDown, bus.resetSome}), 0);

        // Travel 0 -> 3
        tick(10'h008, 1'b0, 1'b0);
        cnt_up = 0; cnt_door = 0; door_fl = -1;
        for (int k = 0; k < 22; k++) begin
            tick('0, 1'b0, 1'b0);
            if (bus.movingUp) cnt_up++;
            if (bus.doorOpen && bus.resetSome == 10'h008) cnt_door++;
            if (bus.doorOpen && door_fl < 0) door_fl = int'(bus.currentFloor);
        end
        lit("t3_up_cycles", cnt_up, 12);
        lit("t3_door_floor", door_fl, 3);
        lit("t3_door_cycles", cnt_door, 3);

        // SCAN from floor 5 with requests above and below
        tick(10'h020, 1'b0, 1'b0);
        settle("t4_to5", 60);
        lit("t4_at5", int'(bus.currentFloor), 5);
        tick(10'h104, 1'b0, 1'b0);
        prev_door = 1'b0;
        for (int k = 0; k < 80; k++) begin
            tick('0, 1'b0, 1'b0);
            if (bus.doorOpen && !prev_door) begin
                door_floors.push_back(int'(bus.currentFloor));
                door_rs.push_back(int'(bus.resetSome));
            end
            prev_door = bus.doorOpen;
        end
        lit("t4_stops", door_floors.size(), 2);
        if (door_floors.size() == 2) begin
            lit("t4_first", door_floors[0], 8);
            lit("t4_first_rs", door_rs[0], 'h100);
            lit("t4_second", door_floors[1], 2);
            lit("t4_second_rs", door_rs[1], 'h004);
        end

        // External clear during the second floor step
        rehome();
        tick(10'h040, 1'b0, 1'b0);
        maxfl = 0; rs_seen = 0;
        for (int k = 0; k < 20; k++) begin
            tick('0, (k == 6), 1'b0);
            if (int'(bus.currentFloor) > maxfl) maxfl = int'(bus.currentFloor);
            if (bus.resetSome != '0) rs_seen++;
        end
        lit("t5_max_floor", maxfl, 2);
        lit("t5_rs_pulses", rs_seen, 0);
        lit("t5_idle", int'({bus.movingUp, bus.movingDown, bus.doorOpen}), 0);

        // Re-press at the open floor
        rehome();
        tick(10'h010, 1'b0, 1'b0);
        nd = 0;
        while (!bus.doorOpen && nd < 40) begin
            tick('0, 1'b0, 1'b0);
            nd++;
        end
        lit("t6_reached", int'(bus.doorOpen), 1);
        cnt_door = 1; cnt_rs = int'(bus.resetSome == 10'h010); rises = 0;
        prev_door = bus.doorOpen;
        for (int k = 0; k < 16; k++) begin
            tick((k == 0) ? 10'h010 : 10'h000, 1'b0, 1'b0);
            if (bus.doorOpen) cnt_door++;
            if (bus.doorOpen && bus.resetSome == 10'h010) cnt_rs++;
            if (bus.doorOpen && !prev_door) rises++;
            prev_door = bus.doorOpen;
        end
        lit("t6_door_cycles", cnt_door, 3);
        lit("t6_rs_cycles", cnt_rs, 3);
        lit("t6_retrigger", rises, 0);

        // Random presses, occasional external clears and resets
        for (int k = 0; k < 1500; k++) begin
            press = '0;
            if ($urandom_range(0, 3) == 0) press[$urandom_range(0, NF-1)] = 1'b1;
            tick(press, ($urandom_range(0, 149) == 0), ($urandom_range(0, 299) == 0));
        end
        reset = 1'b0;
        settle("rand_settle", 400);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/elevator_dispatcher.md
Name: elevator_dispatcher

Overview:
- Consumer end of the floor-request latch bank. Reads the latched request vector, moves the car floor by floor using SCAN (keep direction while requests lie ahead), and opens the door at each requested floor.
- While the door is open, drives the per-floor clear vector back into the latch bank's resetSome input.
- Sits between the request latches and the car motor/door/display logic.

Parameters:
- NUM_FLOORS, 10, number of floors and request bits; floor indices run 0..NUM_FLOORS-1.
- FLOOR_TICKS, 50000000, clk cycles to travel one floor (must be ≥1).
- DOOR_TICKS, 150000000, clk cycles the door stays open (must be ≥1).
- FLOOR_W, $clog2(NUM_FLOORS), width of the floor index.

Ports:
- clk  input  1  system clock; all logic updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- requests  input  NUM_FLOORS  latched floor requests from the latch bank; bit i = floor i pending.
- resetSome  output  NUM_FLOORS  per-floor clear to the latch bank; at most one bit high.
- currentFloor  output  FLOOR_W  floor the car is at or last passed.
- movingUp  output  1  high in MOVE_UP.
- movingDown  output  1  high in MOVE_DOWN.
- doorOpen  output  1  high in DOOR_OPEN.

Behaviour:
- Clock and reset:
  - Single clock domain, clk. Reset is synchronous and active-high, and dominates all other inputs in the cycle it is sampled.
  - Reset values: state=IDLE, currentFloor=0, lastDir=UP, tick counter=0, resetSome=0, movingUp=0, movingDown=0, doorOpen=0.
- Outputs:
  - All outputs are registered or pure decodes of registered state/floor; no combinational path from requests to outputs.
- Derived signals, from the registered floor:
  - above = |requests[NUM_FLOORS-1 : currentFloor+1]
  - below = |requests[currentFloor-1 : 0]
  - here = requests[currentFloor]
  - above is 0 at the top floor; below is 0 at floor 0.
- States: IDLE, MOVE_UP, MOVE_DOWN, DOOR_OPEN.
- IDLE (priority order):
  - here → DOOR_OPEN.
  - else above && (lastDir==UP || !below) → MOVE_UP, lastDir=UP.
  - else below → MOVE_DOWN, lastDir=DOWN.
  - else stay in IDLE.
  - Latency: a request sampled in IDLE produces the state change on the next edge.
- MOVE_UP / MOVE_DOWN:
  - The tick counter counts 0..FLOOR_TICKS-1.
  - At the terminal count: currentFloor ±1, counter clears, and the next state is evaluated using the new floor:
    - request at new floor → DOOR_OPEN
    - else requests further ahead in the same direction → stay moving
    - else → IDLE (reverses from IDLE if needed)
  - One floor step therefore takes exactly FLOOR_TICKS cycles.
  - Floor never goes above NUM_FLOORS-1 or below 0. If a move state is entered with no target ahead (requests dropped), the current step still completes; then the FSM goes to IDLE.
- DOOR_OPEN:
  - Lasts exactly DOOR_TICKS cycles, then → IDLE.
  - resetSome is one-hot on currentFloor for every DOOR_OPEN cycle. Presses at the open floor are absorbed and do not retrigger the door. Zero in all other states.
- requests cleared externally (resetAll) mid-move: no abort; finish the step, then IDLE; no resetSome pulse.
- Simultaneous requests above and below: continue lastDir (SCAN); direction reverses only when nothing remains ahead.
- Reset asserted mid-move or mid-door: immediate return to reset values on that edge; the car position is re-homed to 0 by definition.

Decomposition:
- Shared package: state encoding typedef (IDLE, MOVE_UP, MOVE_DOWN, DOOR_OPEN), direction typedef (UP, DOWN), default NUM_FLOORS constant.
- One natural sub-module, elevator_tick_timer: loadable down-counter producing a terminal pulse. It is instantiated once and reloaded with FLOOR_TICKS or DOOR_TICKS by the FSM.
- Above/below reductions stay inline.

Test Plan (FLOOR_TICKS=4, DOOR_TICKS=3, NUM_FLOORS=10):
1. Reset: assert reset 2 cycles with requests=0x3FF → all outputs 0, currentFloor=0; first cycle after release, state leaves IDLE toward floor 0's request (doorOpen=1).
2. Idle at 0, requests=0x001 → next cycle doorOpen=1 and resetSome=0x001 for exactly 3 cycles, then IDLE with all outputs 0.
3. Idle at 0, requests=0x008:
   - movingUp=1 for 12 cycles; currentFloor 1,2,3 at cycles 4,8,12.
   - Then doorOpen=1 with resetSome=0x008 for 3 cycles.
4. SCAN: at floor 5 after serving an upward request, requests=0x104 (floors 8 and 2) → MOVE_UP to 8 (door, resetSome=0x100), then MOVE_DOWN to 2 (door, resetSome=0x004).
5. Mid-move clear: moving 0→6, requests forced to 0 at cycle 6 → currentFloor reaches 2 at cycle 8, then IDLE; resetSome stays 0 throughout.
6. Press during door: at floor 4 in DOOR_OPEN, requests[4] re-asserted → resetSome[4] stays high, door closes after 3 cycles total, no second DOOR_OPEN.
